opl2_host_if: RTL and testbench
===============================

# opl2_host_if

Host-side register interface for the OPL2 core; it produces the `opl2_reg_wr` stream that `channels`, the operator control logic and every other register consumer snoop. CPU writes to the YM3812 address/data ports go into a write FIFO and are replayed as single-cycle `opl2_reg_wr` transactions at a programmable minimum spacing. The block also implements the YM3812 Timer 1/Timer 2, status register and IRQ, decoded from its own outgoing register writes.

## Interface
Parameters:
- FIFO_DEPTH, 16: write FIFO entries; power of two, at least 2.
- WR_SPACING, 1: minimum number of clk cycles between successive `opl2_reg_wr.valid` pulses; at least 1.

Ports:
- clk, in, 1: single clock for all logic.
- reset, in, 1: asynchronous, active-high; clears all state.
- sample_clk_en, in, 1: one-cycle sample strobe; timer time base.
- cpu_wr, in, 1: one-cycle write strobe, synchronous to clk.
- cpu_rd, in, 1: one-cycle read strobe, synchronous to clk.
- cpu_a0, in, 1: port select; 0 = address/status, 1 = data.
- cpu_din, in, 8: write data.
- cpu_dout, out, 8: read data, registered; reset value 0x00.
- cpu_busy, out, 1: FIFO full; reset value 0.
- fifo_overflow, out, 1: sticky flag for a dropped data write; reset value 0.
- opl2_reg_wr, out, opl2_reg_wr_t: `valid`/`address`/`data`, registered; reset value all zero.
- irq_n, out, 1: active-low interrupt; reset value 1.

## Operation
- Address write (`cpu_wr`, a0=0): the 8-bit address latch takes `cpu_din`. Nothing is pushed to the FIFO. The latch resets to 0x00.
- Data write (`cpu_wr`, a0=1): `{addr_latch, cpu_din}` is pushed into the FIFO.
  - FIFO full: the write is dropped and `fifo_overflow` is set. The flag clears only on reset.
  - The address latch is retained, so repeated data writes go to the same register.
- Simultaneous `cpu_wr` and `cpu_rd`: the write is performed and the read is ignored.
- Pop: the FIFO pops when it is non-empty and the spacing counter is 0.
  - The popped entry drives `opl2_reg_wr` with `valid`=1 for exactly one cycle, and the spacing counter loads WR_SPACING-1.
  - The counter decrements to 0 on later cycles. `address`/`data` hold their last values while `valid`=0.
- A push and a pop in the same cycle both take effect, and the occupancy is unchanged.
- Timer registers are decoded from outgoing `opl2_reg_wr` pulses and are also forwarded:
  - 0x02 sets TLL1; 0x03 sets TLL2.
  - 0x04 with bit7=1 clears FT1, FT2 and IRQ, and its other bits are ignored.
  - 0x04 with bit7=0 loads ST1=bit0, ST2=bit1, MASK2=bit5, MASK1=bit6.
- Timer n:
  - On a 0→1 transition of STn, the counter loads TLLn and the prescaler clears.
  - The prescaler counts `sample_clk_en` pulses: 4 for Timer 1 (≈80 µs), 16 for Timer 2 (≈320 µs).
  - Each prescaler wrap increments the counter. An increment from 0xFF reloads TLLn and, if MASKn=0, sets FTn.
  - While STn=0 the counter and prescaler hold.
- Status = {IRQ, FT1, FT2, 5'b0}, where IRQ = FT1|FT2. `irq_n` = ~IRQ, registered.
- Read (`cpu_rd`): a0=0 returns the status; a0=1 returns 0x00.

## Timing
- Write latency: data write sampled at edge E into an empty FIFO with the spacing counter at 0 gives `opl2_reg_wr.valid`=1 in the cycle after edge E+1.
- Throughput: one transaction every WR_SPACING cycles while the FIFO is non-empty.
- `cpu_busy` updates in the cycle after the push that fills the FIFO. The host must not issue a data write while `cpu_busy`=1, or the write is dropped.
- Read latency: `cpu_rd` at edge E gives `cpu_dout` valid after edge E, held until the next read.
- FT set → `irq_n` low one cycle later.
- Register-write effects: the 0x04 reset write clears the flags on the edge after its `opl2_reg_wr.valid` cycle. If a timer overflow coincides with the clearing write, the clear wins.
- Reset mid-operation: the FIFO is flushed without emitting entries, all timers stop, and all outputs return to their reset values.

## Configuration
- OPL2_TIMERS_EN defined: timers, status register and IRQ are implemented as described.
- OPL2_TIMERS_EN undefined: timer logic is omitted, status reads return 0x00, and `irq_n` is tied to 1. Register writes to 0x02–0x04 are still forwarded unchanged.

## Structure
- The following go in `opl2_pkg`:
  - the existing `opl2_reg_wr_t`;
  - constants for timer register addresses 0x02/0x03/0x04;
  - status bit positions (IRQ=7, FT1=6, FT2=5);
  - timer prescales 4/16.
- Sub-module `opl2_timer` (parameter PRESCALE; inputs tll, st, mask, clear, sample_clk_en; output flag) is instantiated twice. The FIFO is inline.

## Test plan
- Burst: write addr 0x20, then data 0x01..0x05 → five `valid` pulses, address 0x20, data 0x01..0x05 in order, back-to-back (WR_SPACING=1).
- Spacing: with WR_SPACING=4, three queued writes → `valid` pulses exactly 4 cycles apart.
- Overflow: FIFO_DEPTH+1 data writes with no pops possible (WR_SPACING large) → `cpu_busy`=1, `fifo_overflow`=1, and exactly FIFO_DEPTH entries are emitted afterwards.
- Timer 1: TLL1=0xFE, 0x04←0x01 → FT1 set and `irq_n` low after 8 `sample_clk_en` pulses; status read = 0xC0.
- Masking and IRQ reset: Timer 2 with MASK2=1 → no flag. Then FT1 set and 0x04←0x80 → status 0x00, `irq_n`=1.
- Reset mid-burst: assert reset with 3 entries queued → no further `valid`, all outputs at reset values, FIFO empty after release.

Source files
------------

// File: rtl/opl2_pkg.sv
// opl2_pkg: shared types and constants for the OPL2 host interface.
//   opl2_reg_wr_t  - register write transaction (valid/address/data)
//   REG_*          - timer register addresses
//   STAT_*         - status register bit positions
//   T*_PRESCALE    - sample_clk_en pulses per timer tick
package opl2_pkg;

  typedef struct packed {
    logic       valid;
    logic [7:0] address;
    logic [7:0] data;
  } opl2_reg_wr_t;

  localparam logic [7:0] REG_TLL1  = 8'h02;
  localparam logic [7:0] REG_TLL2  = 8'h03;
  localparam logic [7:0] REG_TCTRL = 8'h04;

  localparam int STAT_IRQ = 7;
  localparam int STAT_FT1 = 6;
  localparam int STAT_FT2 = 5;

  localparam int T1_PRESCALE = 4;
  localparam int T2_PRESCALE = 16;

endpackage

// File: rtl/opl2_timer.sv
// opl2_timer: one YM3812 up-counting timer with prescaler and overflow flag.
// Ports:
//   clk, rst       - clock, async active-high reset
//   sample_clk_en  - sample strobe, time base for the prescaler
//   tll            - reload value
//   st             - run enable; a 0->1 edge reloads the counter
//   mask           - suppresses setting the flag on overflow
//   clear          - clears the flag (wins over a coincident overflow)
//   flag           - overflow flag
module opl2_timer #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_clk_en,
  input  logic [7:0] tll,
  input  logic       st,
  input  logic       mask,
  input  logic       clear,
  output logic       flag
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pre;
  logic [7:0]    cnt;
  logic          st_q;
  logic          tick;
  logic          ovf;

  // st_q gates tick so the start cycle only performs the reload
  assign tick = st && st_q && sample_clk_en && (pre == PW'(PRESCALE - 1));
  assign ovf  = tick && (cnt == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      cnt  <= '0;
      st_q <= 1'b0;
      flag <= 1'b0;
    end else begin
      st_q <= st;
      if (st && !st_q) begin
        cnt <= tll;
        pre <= '0;
      end else if (st && sample_clk_en) begin
        pre <= pre + PW'(1);
        if (tick)
          cnt <= (cnt == 8'hFF) ? tll : cnt + 8'd1;
      end
      if (clear)
        flag <= 1'b0;
      else if (ovf && !mask)
        flag <= 1'b1;
    end
  end

endmodule

// File: rtl/opl2_host_if.sv
// opl2_host_if: CPU-side YM3812 port interface. Data writes are queued in a
// FIFO and replayed on opl2_reg_wr at a minimum spacing of WR_SPACING cycles.
// Timer 1/2, status and IRQ are decoded from the outgoing writes when the
// macro OPL2_TIMERS_EN is defined; otherwise status reads 0x00, irq_n = 1.
// Ports:
//   clk, reset                 - clock, async active-high reset
//   sample_clk_en              - timer time base
//   cpu_wr, cpu_rd, cpu_a0     - host strobes and port select
//   cpu_din / cpu_dout         - host write data / registered read data
//   cpu_busy                   - FIFO full
//   fifo_overflow              - sticky: a data write was dropped
//   opl2_reg_wr                - registered register-write stream
//   irq_n                      - active-low interrupt
module opl2_host_if
  import opl2_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int WR_SPACING = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_clk_en,
  input  logic         cpu_wr,
  input  logic         cpu_rd,
  input  logic         cpu_a0,
  input  logic [7:0]   cpu_din,
  output logic [7:0]   cpu_dout,
  output logic         cpu_busy,
  output logic         fifo_overflow,
  output opl2_reg_wr_t opl2_reg_wr,
  output logic         irq_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] spc;
  logic [7:0]    addr_latch;
  logic [7:0]    status;
  logic          full, data_wr, push, pop;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign data_wr  = cpu_wr && cpu_a0;
  assign push     = data_wr && !full;
  assign pop      = (count != '0) && (spc == '0);
  assign cpu_busy = full;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {addr_latch, cpu_din};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_latch    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      spc           <= '0;
      fifo_overflow <= 1'b0;
      opl2_reg_wr   <= '0;
      cpu_dout      <= '0;
    end else begin
      if (cpu_wr && !cpu_a0)
        addr_latch <= cpu_din;
      if (data_wr && full)
        fifo_overflow <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr            <= rd_ptr + AW'(1);
        opl2_reg_wr.valid <= 1'b1;
        {opl2_reg_wr.address, opl2_reg_wr.data} <= mem[rd_ptr];
        spc               <= SW'(WR_SPACING - 1);
      end else begin
        opl2_reg_wr.valid <= 1'b0;
        if (spc != '0)
          spc <= spc - SW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      // a write in the same cycle takes precedence over a read
      if (cpu_rd && !cpu_wr)
        cpu_dout <= cpu_a0 ? 8'h00 : status;
    end
  end

`ifdef OPL2_TIMERS_EN
  logic [7:0] tll1, tll2;
  logic       st1, st2, mask1, mask2;
  logic       ft1, ft2, flag_clr;

  assign flag_clr = opl2_reg_wr.valid && (opl2_reg_wr.address == REG_TCTRL) &&
                    opl2_reg_wr.data[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tll1  <= '0;
      tll2  <= '0;
      st1   <= 1'b0;
      st2   <= 1'b0;
      mask1 <= 1'b0;
      mask2 <= 1'b0;
      irq_n <= 1'b1;
    end else begin
      irq_n <= ~(ft1 | ft2);
      if (opl2_reg_wr.valid) begin
        case (opl2_reg_wr.address)
          REG_TLL1: tll1 <= opl2_reg_wr.data;
          REG_TLL2: tll2 <= opl2_reg_wr.data;
          REG_TCTRL: begin
            if (!opl2_reg_wr.data[7]) begin
              st1   <= opl2_reg_wr.data[0];
              st2   <= opl2_reg_wr.data[1];
              mask2 <= opl2_reg_wr.data[5];
              mask1 <= opl2_reg_wr.data[6];
            end
          end
          default: ;
        endcase
      end
    end
  end

  opl2_timer #(.PRESCALE(T1_PRESCALE)) u_timer1 (
    .clk(clk), .rst(reset), .sample_clk_en(sample_clk_en),
    .tll(tll1), .st(st1), .mask(mask1), .clear(flag_clr), .flag(ft1)
  );

  opl2_timer #(.PRESCALE(T2_PRESCALE)) u_timer2 (
    .clk(clk), .rst(reset), .sample_clk_en(sample_clk_en),
    .tll(tll2), .st(st2), .mask(mask2), .clear(flag_clr), .flag(ft2)
  );

  always_comb begin
    status           = 8'h00;
    status[STAT_IRQ] = ft1 | ft2;
    status[STAT_FT1] = ft1;
    status[STAT_FT2] = ft2;
  end
`else
  logic unused_sample_clk_en;
  assign unused_sample_clk_en = sample_clk_en;
  assign status = 8'h00;
  assign irq_n  = 1'b1;
`endif

endmodule

// File: tb/tb_opl2_host_if.sv
module tb_opl2_host_if;
  import opl2_pkg::*;

`ifdef OPL2_TIMERS_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, sce = 1'b0;
  logic [2:0] wr_sel = '0;
  logic rd = 1'b0, a0 = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] dout_a, dout_b, dout_c;
  logic busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c, irqn_a, irqn_b, irqn_c;
  opl2_reg_wr_t rw_a, rw_b, rw_c;

  opl2_host_if #(.FIFO_DEPTH(16), .WR_SPACING(1)) dut_a (
    .clk(clk), .reset(reset), .sample_clk_en(sce), .cpu_wr(wr_sel[0]), .cpu_rd(rd),
    .cpu_a0(a0), .cpu_din(din), .cpu_dout(dout_a), .cpu_busy(busy_a),
    .fifo_overflow(ovf_a), .opl2_reg_wr(rw_a), .irq_n(irqn_a));
  opl2_host_if #(.FIFO_DEPTH(16), .WR_SPACING(4)) dut_b (
    .clk(clk), .reset(reset), .sample_clk_en(sce), .cpu_wr(wr_sel[1]), .cpu_rd(rd),
    .cpu_a0(a0), .cpu_din(din), .cpu_dout(dout_b), .cpu_busy(busy_b),
    .fifo_overflow(ovf_b), .opl2_reg_wr(rw_b), .irq_n(irqn_b));
  opl2_host_if #(.FIFO_DEPTH(4), .WR_SPACING(40)) dut_c (
    .clk(clk), .reset(reset), .sample_clk_en(sce), .cpu_wr(wr_sel[2]), .cpu_rd(rd),
    .cpu_a0(a0), .cpu_din(din), .cpu_dout(dout_c), .cpu_busy(busy_c),
    .fifo_overflow(ovf_c), .opl2_reg_wr(rw_c), .irq_n(irqn_c));

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct { logic [7:0] a; logic [7:0] d; int t; } obs_t;
  obs_t obs_a[$], obs_b[$], obs_c[$];
  logic [15:0] exp_a[$], exp_b[$], exp_c[$];

  always @(negedge clk) begin
    if (rw_a.valid) obs_a.push_back('{rw_a.address, rw_a.data, cyc_cnt});
    if (rw_b.valid) obs_b.push_back('{rw_b.address, rw_b.data, cyc_cnt});
    if (rw_c.valid) obs_c.push_back('{rw_c.address, rw_c.data, cyc_cnt});
  end

  int total = 0, bad = 0;

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int inst, input logic a, input logic [7:0] d);
    wr_sel = 3'b001 << inst; a0 = a; din = d;
    cyc();
    wr_sel = '0;
  endtask

  task automatic rd_stat(output logic [7:0] v);
    rd = 1'b1; a0 = 1'b0;
    cyc();
    rd = 1'b0;
    v = dout_a;
  endtask

  task automatic pulse_sce(input int n);
    repeat (n) begin sce = 1'b1; cyc(); sce = 1'b0; cyc(2); end
  endtask

  function automatic int obs_size(input int inst);
    return (inst == 0) ? obs_a.size() : (inst == 1) ? obs_b.size() : obs_c.size();
  endfunction

  // bounded wait; returns 1 if n observations arrived
  task automatic wait_obs(input int inst, input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && obs_size(inst) < n; i++) cyc();
    ok = (obs_size(inst) >= n);
  endtask

  task automatic test_reset;
    cyc(3);
    total++; if (dout_a !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", dout_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf_a); end
    total++; if (rw_a !== '0) begin bad++; $display("FAIL reset_regwr got=%h want=0", rw_a); end
    total++; if (irqn_a !== 1'b1) begin bad++; $display("FAIL reset_irqn got=%b want=1", irqn_a); end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_burst;
    int t_push, t_prev; bit ok; obs_t o; logic [15:0] e;
    wr(0, 1'b0, 8'h20);
    for (int i = 1; i <= 5; i++) begin
      wr(0, 1'b1, 8'(i));
      if (i == 1) t_push = cyc_cnt;
      exp_a.push_back({8'h20, 8'(i)});
    end
    wait_obs(0, 5, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL burst_count got=%0d want=5", obs_a.size()); end
    t_prev = t_push;
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      total++; if ({o.a, o.d} !== e) begin bad++; $display("FAIL burst_data got=%h%h want=%h", o.a, o.d, e); end
      total++; if (o.t !== t_prev + 1) begin bad++; $display("FAIL burst_timing got=%0d want=%0d", o.t, t_prev + 1); end
      t_prev = o.t;
    end
    exp_a.delete();
  endtask

  task automatic test_spacing;
    int t_push, t_prev; bit ok; obs_t o; logic [15:0] e;
    wr(1, 1'b0, 8'h40);
    for (int i = 1; i <= 3; i++) begin
      wr(1, 1'b1, 8'hA0 + 8'(i));
      if (i == 1) t_push = cyc_cnt;
      exp_b.push_back({8'h40, 8'hA0 + 8'(i)});
    end
    wait_obs(1, 3, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL spacing_count got=%0d want=3", obs_b.size()); end
    for (int i = 0; obs_b.size() > 0 && exp_b.size() > 0; i++) begin
      o = obs_b.pop_front(); e = exp_b.pop_front();
      total++; if ({o.a, o.d} !== e) begin bad++; $display("FAIL spacing_data got=%h%h want=%h", o.a, o.d, e); end
      if (i == 0) begin
        total++; if (o.t !== t_push + 1) begin bad++; $display("FAIL spacing_latency got=%0d want=%0d", o.t, t_push + 1); end
      end else begin
        total++; if (o.t - t_prev !== 4) begin bad++; $display("FAIL spacing_gap got=%0d want=4", o.t - t_prev); end
      end
      t_prev = o.t;
    end
    exp_b.delete();
  endtask

  task automatic test_overflow;
    bit ok; obs_t o; logic [15:0] e;
    wr(2, 1'b0, 8'h60);
    wr(2, 1'b1, 8'h00);
    wait_obs(2, 1, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_prime got=%0d want=1", obs_c.size()); end
    obs_c.delete();
    // spacing counter is now loaded; no pop is possible for the next writes
    for (int i = 0; i < 5; i++) begin
      wr(2, 1'b1, 8'h10 + 8'(i));
      if (i < 4) exp_c.push_back({8'h60, 8'h10 + 8'(i)});
      if (i == 3) begin
        total++; if (busy_c !== 1'b1) begin bad++; $display("FAIL ovf_busy got=%b want=1", busy_c); end
        total++; if (ovf_c !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", ovf_c); end
      end
    end
    total++; if (ovf_c !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", ovf_c); end
    wait_obs(2, 4, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_drain got=%0d want=4", obs_c.size()); end
    cyc(100);
    total++; if (obs_c.size() !== 4) begin bad++; $display("FAIL ovf_emitted got=%0d want=4", obs_c.size()); end
    while (obs_c.size() > 0 && exp_c.size() > 0) begin
      o = obs_c.pop_front(); e = exp_c.pop_front();
      total++; if ({o.a, o.d} !== e) begin bad++; $display("FAIL ovf_data got=%h%h want=%h", o.a, o.d, e); end
    end
    obs_c.delete(); exp_c.delete();
    total++; if (busy_c !== 1'b0) begin bad++; $display("FAIL ovf_busy_clr got=%b want=0", busy_c); end
    total++; if (ovf_c !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf_c); end
  endtask

  task automatic test_timer1;
    logic [7:0] s; obs_t o; logic [15:0] e;
    wr(0, 1'b0, REG_TLL1);  wr(0, 1'b1, 8'hFE); exp_a.push_back({REG_TLL1, 8'hFE});
    wr(0, 1'b0, REG_TCTRL); wr(0, 1'b1, 8'h01); exp_a.push_back({REG_TCTRL, 8'h01});
    cyc(10);
    total++; if (obs_a.size() !== 2) begin bad++; $display("FAIL tmr_fwd_count got=%0d want=2", obs_a.size()); end
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      o = obs_a.pop_front(); e = exp_a.pop_front();
      total++; if ({o.a, o.d} !== e) begin bad++; $display("FAIL tmr_fwd got=%h%h want=%h", o.a, o.d, e); end
    end
    obs_a.delete(); exp_a.delete();
    pulse_sce(7);
    rd_stat(s);
    total++; if (s !== 8'h00) begin bad++; $display("FAIL tmr1_early got=%h want=00", s); end
    total++; if (irqn_a !== 1'b1) begin bad++; $display("FAIL tmr1_irq_early got=%b want=1", irqn_a); end
    pulse_sce(1);
    total++; if (irqn_a !== !TMR) begin bad++; $display("FAIL tmr1_irqn got=%b want=%b", irqn_a, !TMR); end
    rd_stat(s);
    total++; if (s !== (TMR ? 8'hC0 : 8'h00)) begin bad++; $display("FAIL tmr1_status got=%h want=%h", s, TMR ? 8'hC0 : 8'h00); end
  endtask

  task automatic test_mask_irq_reset;
    logic [7:0] s;
    wr(0, 1'b0, REG_TCTRL); wr(0, 1'b1, 8'h80);
    wr(0, 1'b0, REG_TLL2);  wr(0, 1'b1, 8'hFF);
    wr(0, 1'b0, REG_TCTRL); wr(0, 1'b1, 8'h22);
    cyc(10);
    pulse_sce(20);
    rd_stat(s);
    total++; if (s !== 8'h00) begin bad++; $display("FAIL mask2_status got=%h want=00", s); end
    total++; if (irqn_a !== 1'b1) begin bad++; $display("FAIL mask2_irqn got=%b want=1", irqn_a); end
    wr(0, 1'b0, REG_TLL1);  wr(0, 1'b1, 8'hFF);
    wr(0, 1'b0, REG_TCTRL); wr(0, 1'b1, 8'h01);
    cyc(10);
    pulse_sce(4);
    rd_stat(s);
    total++; if (s !== (TMR ? 8'hC0 : 8'h00)) begin bad++; $display("FAIL ft1_status got=%h want=%h", s, TMR ? 8'hC0 : 8'h00); end
    total++; if (irqn_a !== !TMR) begin bad++; $display("FAIL ft1_irqn got=%b want=%b", irqn_a, !TMR); end
    wr(0, 1'b0, REG_TCTRL); wr(0, 1'b1, 8'h80);
    cyc(5);
    rd_stat(s);
    total++; if (s !== 8'h00) begin bad++; $display("FAIL irqrst_status got=%h want=00", s); end
    total++; if (irqn_a !== 1'b1) begin bad++; $display("FAIL irqrst_irqn got=%b want=1", irqn_a); end
    obs_a.delete();
  endtask

  task automatic test_reset_mid;
    bit ok; obs_t o;
    wr(1, 1'b0, 8'h50);
    for (int i = 0; i < 4; i++) wr(1, 1'b1, 8'hB0 + 8'(i));
    wait_obs(1, 1, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_first got=%0d want=1", obs_b.size()); end
    obs_b.delete();
    reset = 1'b1;
    cyc(1);
    total++; if (rw_b !== '0) begin bad++; $display("FAIL rstmid_regwr got=%h want=0", rw_b); end
    total++; if (busy_b !== 1'b0 || dout_b !== 8'h00 || irqn_b !== 1'b1) begin
      bad++; $display("FAIL rstmid_outs got=%b/%h/%b want=0/00/1", busy_b, dout_b, irqn_b); end
    total++; if (ovf_c !== 1'b0) begin bad++; $display("FAIL rstmid_ovf got=%b want=0", ovf_c); end
    cyc(2);
    reset = 1'b0;
    cyc(30);
    total++; if (obs_b.size() !== 0) begin bad++; $display("FAIL rstmid_flush got=%0d want=0", obs_b.size()); end
    obs_b.delete();
    wr(1, 1'b1, 8'h77);
    wait_obs(1, 1, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_post got=%0d want=1", obs_b.size()); end
    if (obs_b.size() > 0) begin
      o = obs_b.pop_front();
      total++; if ({o.a, o.d} !== 16'h0077) begin bad++; $display("FAIL rstmid_latch got=%h%h want=0077", o.a, o.d); end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_spacing();
    test_overflow();
    test_timer1();
    test_mask_irq_reset();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
